axis_block_detector: RTL and testbench
======================================

AXIS_BLOCK_DETECTOR -- requirements
Module: axis_block_detector

Interface
REQ-001 Parameter NUM_CH, default 4: number of monitored AXI-Stream channels.
REQ-002 Parameter STALL_THRESH, default 16: consecutive stalled cycles before a channel is flagged blocked; legal range 1..65535.
REQ-003 Parameter RD_MASK, default 4'b0001: bit i = 1 means the DUT reads channel i; bit i = 0 means the DUT writes channel i.
REQ-004 Port clock, in, 1: single clock; all logic on posedge.
REQ-005 Port reset, in, 1: synchronous, active-high reset.
REQ-006 Port en, in, 1: monitor enable.
REQ-007 Port clear, in, 1: one-cycle pulse that clears the sticky first-block record.
REQ-008 Port ch_tvalid, in, NUM_CH: TVALID of each monitored channel.
REQ-009 Port ch_tready, in, NUM_CH: TREADY of each monitored channel.
REQ-010 Port axis_block_sigs, out, NUM_CH: per-channel blocked flag, registered; feeds the deadlock monitor input of the same name.
REQ-011 Port block_any, out, 1: OR of axis_block_sigs, registered.
REQ-012 Port first_block_vld, out, 1: sticky; a first-block record is held.
REQ-013 Port first_block_ch, out, clog2(NUM_CH): index of the first channel to become blocked.
REQ-014 Port stall_max, out, 16: largest completed or ongoing stall run on any channel, saturating at 16'hFFFF.

Function
REQ-015 Stall condition, channel i read (RD_MASK[i]=1): ch_tready[i] & ~ch_tvalid[i].
REQ-016 Stall condition, channel i written (RD_MASK[i]=0): ch_tvalid[i] & ~ch_tready[i].
REQ-017 Stall condition is always false when tvalid & tready, i.e. a completed beat.
REQ-018 Each channel runs an FSM with states IDLE, COUNT and BLOCKED, plus a 16-bit run counter.
REQ-019 IDLE: stall -> COUNT with counter = 1; else stay in IDLE with counter = 0.
REQ-020 COUNT: no stall -> IDLE with counter = 0; stall with counter+1 == STALL_THRESH -> BLOCKED; stall otherwise -> stay in COUNT with counter +1.
REQ-021 STALL_THRESH = 1: a stall in IDLE goes directly to BLOCKED.
REQ-022 BLOCKED: stall -> stay in BLOCKED, counter increments and saturates at 16'hFFFF; no stall -> IDLE with counter = 0.
REQ-023 axis_block_sigs[i] is 1 exactly while channel i's FSM is in BLOCKED; it is a registered state decode with no combinational path from inputs.
REQ-024 Latency: stall first present in cycle 0 and held -> axis_block_sigs[i] = 1 from cycle STALL_THRESH onward; stall removed in cycle k -> bit = 0 from cycle k+1.
REQ-025 block_any tracks the OR of axis_block_sigs with no added delay, i.e. it is registered on the same edge.
REQ-026 When first_block_vld = 0 and one or more channels enter BLOCKED on the same edge: first_block_vld <= 1 and first_block_ch <= lowest such index.
REQ-027 When first_block_vld = 1, first_block_ch holds until clear.
REQ-028 clear clears first_block_vld and first_block_ch and zeroes stall_max.
REQ-029 clear coinciding with a new block entry: the new entry wins, the record is reloaded and stall_max is reloaded from current counters.
REQ-030 stall_max <= max(stall_max, all channel counters) every cycle.
REQ-031 en = 0: all FSMs forced to IDLE and counters zeroed on the next edge; axis_block_sigs and block_any = 0 the cycle after; sticky record and stall_max are held.
REQ-032 en rising: counting restarts from 0; a stall already in progress is not credited.

Reset
REQ-033 On reset: all FSMs in IDLE; counters, axis_block_sigs, block_any, first_block_vld, first_block_ch and stall_max all = 0.
REQ-034 Reset asserted mid-run discards all in-progress counts; reset overrides en and clear.

Structure
REQ-035 A shared package holds the FSM state enum (IDLE, COUNT, BLOCKED), the counter width constant (16) and the saturation value.
REQ-036 One sub-module, axis_block_chan, implements the per-channel FSM and counter; it is instantiated NUM_CH times by generate.
REQ-037 The top level holds the first-block priority encoder, the max tree and the registers for block_any and stall_max.

Verification
REQ-038 THRESH=16, ch0 read, tready=1, tvalid=0 held for 20 cycles from cycle 0 -> axis_block_sigs = 4'b0001 from cycle 16; first_block_ch = 0; first_block_vld = 1.
REQ-039 ch2 write, stall 15 cycles, one beat, stall 15 cycles -> axis_block_sigs[2] never asserts; stall_max = 15.
REQ-040 ch1 and ch3 stall starting the same cycle -> both bits set at cycle 16; first_block_ch = 1; a later ch0 block leaves first_block_ch = 1.
REQ-041 ch3 BLOCKED, then en = 0 -> bit clears the next cycle; first_block_vld stays 1; en = 1 with the stall continuing -> bit reasserts 16 cycles later.
REQ-042 Reset asserted at cycle 10 of a stall, stall held -> all outputs 0; bit asserts 16 cycles after reset deasserts.
REQ-043 STALL_THRESH = 1 -> bit asserts the cycle after the first stalled cycle; a stall of 70000 cycles -> stall_max = 16'hFFFF with no wrap.

Source files
------------

// File: rtl/axis_block_detector_pkg.sv
// Shared types for the AXI-Stream block detector: the per-channel FSM state, the run
// counter width and the value at which the run counter saturates.
package axis_block_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_BLOCKED = 2'd2
  } chan_state_e;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/axis_block_chan.sv
// Per-channel stall tracker: IDLE/COUNT/BLOCKED FSM with a saturating 16-bit run counter.
// blocked is the decode of registered state; blocked_nxt is the next-state view for the top.
module axis_block_chan
  import axis_block_detector_pkg::*;
#(
  parameter int STALL_THRESH = 16,
  parameter bit IS_RD        = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             tvalid,
  input  logic             tready,
  output logic             blocked,
  output logic             blocked_nxt,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(STALL_THRESH);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall;

  // A reader stalls when it is ready but starved; a writer stalls when it offers but is refused.
  assign stall = IS_RD ? (tready & ~tvalid) : (tvalid & ~tready);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stall) begin
            cnt_d   = CNT_W'(1);
            state_d = (THRESH_C == CNT_W'(1)) ? ST_BLOCKED : ST_COUNT;
          end else begin
            cnt_d = '0;
          end
        end
        ST_COUNT: begin
          if (stall) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_d == THRESH_C) ? ST_BLOCKED : ST_COUNT;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_BLOCKED: begin
          if (stall) begin
            cnt_d = sat_inc(cnt_q);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign blocked     = (state_q == ST_BLOCKED);
  assign blocked_nxt = (state_d == ST_BLOCKED);
  assign cnt         = cnt_q;

endmodule

// File: rtl/axis_block_detector.sv
// Flags AXI-Stream channels stalled for STALL_THRESH cycles; keeps a sticky first-block record
// and the longest stall run seen. Passive monitor: observes handshakes, never drives backpressure.
module axis_block_detector
  import axis_block_detector_pkg::*;
#(
  parameter int                NUM_CH       = 4,
  parameter int                STALL_THRESH = 16,
  parameter logic [NUM_CH-1:0] RD_MASK      = NUM_CH'(1),
  localparam int               CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              block_any,
  output logic              first_block_vld,
  output logic [CH_W-1:0]   first_block_ch,
  output logic [CNT_W-1:0]  stall_max
);

  logic [NUM_CH-1:0] blk;
  logic [NUM_CH-1:0] blk_nxt;
  logic [CNT_W-1:0]  cnt [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    axis_block_chan #(
      .STALL_THRESH(STALL_THRESH),
      .IS_RD       (RD_MASK[i])
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .en         (en),
      .tvalid     (ch_tvalid[i]),
      .tready     (ch_tready[i]),
      .blocked    (blk[i]),
      .blocked_nxt(blk_nxt[i]),
      .cnt        (cnt[i])
    );
  end

  logic              block_any_q, block_any_d;
  logic              first_vld_q, first_vld_d;
  logic [CH_W-1:0]   first_ch_q, first_ch_d;
  logic [CNT_W-1:0]  stall_max_q, stall_max_d;
  logic [NUM_CH-1:0] enter;
  logic              entry_any;
  logic [CH_W-1:0]   entry_ch;
  logic [CNT_W-1:0]  cnt_max;

  always_comb begin
    enter     = blk_nxt & ~blk;
    entry_any = |enter;
    entry_ch  = '0;
    // Walk downward so the lowest entering index is the one left standing.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (enter[i]) entry_ch = CH_W'(i);
    end
    cnt_max = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt[i] > cnt_max) cnt_max = cnt[i];
    end
  end

  always_comb begin
    block_any_d = |blk_nxt;
    first_vld_d = first_vld_q;
    first_ch_d  = first_ch_q;
    stall_max_d = (cnt_max > stall_max_q) ? cnt_max : stall_max_q;
    if (clear) begin
      first_vld_d = 1'b0;
      first_ch_d  = '0;
      stall_max_d = '0;
    end
    // A block entry on the clearing edge wins over the clear.
    if (entry_any && (!first_vld_q || clear)) begin
      first_vld_d = 1'b1;
      first_ch_d  = entry_ch;
    end
    if (clear && entry_any) stall_max_d = cnt_max;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      block_any_q <= 1'b0;
      first_vld_q <= 1'b0;
      first_ch_q  <= '0;
      stall_max_q <= '0;
    end else begin
      block_any_q <= block_any_d;
      first_vld_q <= first_vld_d;
      first_ch_q  <= first_ch_d;
      stall_max_q <= stall_max_d;
    end
  end

  assign axis_block_sigs = blk;
  assign block_any       = block_any_q;
  assign first_block_vld = first_vld_q;
  assign first_block_ch  = first_ch_q;
  assign stall_max       = stall_max_q;

endmodule

// File: tb/tb_axis_block_detector.sv
// Directed bench for axis_block_detector: default instance (threshold 16) plus a threshold-1 instance.
module tb_axis_block_detector;

  logic        clock;
  logic        reset;
  logic        en;
  logic        clear;
  logic [3:0]  tvalid, tready;
  logic [3:0]  t1_tvalid, t1_tready;

  logic [3:0]  sigs;
  logic        any;
  logic        fvld;
  logic [1:0]  fch;
  logic [15:0] smax;

  logic [3:0]  d1_sigs;
  logic        d1_any;
  logic        d1_fvld;
  logic [1:0]  d1_fch;
  logic [15:0] d1_smax;

  int total = 0;
  int bad   = 0;

  axis_block_detector dut (
    .clock          (clock),
    .reset          (reset),
    .en             (en),
    .clear          (clear),
    .ch_tvalid      (tvalid),
    .ch_tready      (tready),
    .axis_block_sigs(sigs),
    .block_any      (any),
    .first_block_vld(fvld),
    .first_block_ch (fch),
    .stall_max      (smax)
  );

  axis_block_detector #(.STALL_THRESH(1)) dut1 (
    .clock          (clock),
    .reset          (reset),
    .en             (en),
    .clear          (clear),
    .ch_tvalid      (t1_tvalid),
    .ch_tready      (t1_tready),
    .axis_block_sigs(d1_sigs),
    .block_any      (d1_any),
    .first_block_vld(d1_fvld),
    .first_block_ch (d1_fch),
    .stall_max      (d1_smax)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; en = 1'b1; clear = 1'b0;
    tvalid = '0; tready = '0; t1_tvalid = '0; t1_tready = '0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b1; clear = 1'b1;
    tvalid = 4'b1110; tready = 4'b0000; t1_tvalid = '0; t1_tready = 4'b0001;
    for (int c = 0; c < 5; c++) tick;
    total++; if (sigs !== 4'b0000) begin bad++; $display("FAIL reset_sigs got=%b exp=0000", sigs); end
    total++; if (any !== 1'b0) begin bad++; $display("FAIL reset_any got=%b exp=0", any); end
    total++; if (fvld !== 1'b0) begin bad++; $display("FAIL reset_fvld got=%b exp=0", fvld); end
    total++; if (fch !== 2'd0) begin bad++; $display("FAIL reset_fch got=%0d exp=0", fch); end
    total++; if (smax !== 16'd0) begin bad++; $display("FAIL reset_smax got=%0d exp=0", smax); end
    total++; if (d1_sigs !== 4'b0000) begin bad++; $display("FAIL reset_d1_sigs got=%b exp=0000", d1_sigs); end
    total++; if (d1_smax !== 16'd0) begin bad++; $display("FAIL reset_d1_smax got=%0d exp=0", d1_smax); end
    reset = 1'b0; clear = 1'b0; tvalid = '0; t1_tready = '0;
  endtask

  task automatic test_single_block;
    logic [3:0] exp;
    do_reset;
    tready = 4'b0001;
    for (int c = 1; c <= 20; c++) begin
      tick;
      exp = (c >= 16) ? 4'b0001 : 4'b0000;
      total++; if (sigs !== exp) begin bad++; $display("FAIL single_sigs c=%0d got=%b exp=%b", c, sigs, exp); end
      total++; if (any !== |exp) begin bad++; $display("FAIL single_any c=%0d got=%b exp=%b", c, any, |exp); end
      if (c == 16) begin
        total++; if (fvld !== 1'b1) begin bad++; $display("FAIL single_fvld got=%b exp=1", fvld); end
        total++; if (fch !== 2'd0) begin bad++; $display("FAIL single_fch got=%0d exp=0", fch); end
      end
    end
    tready = 4'b0000;
    tick;
    total++; if (sigs !== 4'b0000) begin bad++; $display("FAIL single_release got=%b exp=0000", sigs); end
    total++; if (smax !== 16'd20) begin bad++; $display("FAIL single_smax got=%0d exp=20", smax); end
    total++; if (fvld !== 1'b1) begin bad++; $display("FAIL single_sticky got=%b exp=1", fvld); end
  endtask

  task automatic test_no_block;
    do_reset;
    tvalid = 4'b0100;
    for (int c = 0; c < 15; c++) begin
      tick;
      total++; if (sigs !== 4'b0000) begin bad++; $display("FAIL noblk_a c=%0d got=%b exp=0000", c, sigs); end
    end
    tready = 4'b0100;
    tick;
    tready = 4'b0000;
    for (int c = 0; c < 15; c++) begin
      tick;
      total++; if (sigs !== 4'b0000) begin bad++; $display("FAIL noblk_b c=%0d got=%b exp=0000", c, sigs); end
    end
    tvalid = 4'b0000;
    tick;
    tick;
    total++; if (smax !== 16'd15) begin bad++; $display("FAIL noblk_smax got=%0d exp=15", smax); end
    total++; if (fvld !== 1'b0) begin bad++; $display("FAIL noblk_fvld got=%b exp=0", fvld); end
  endtask

  task automatic test_simultaneous;
    do_reset;
    tvalid = 4'b1010;
    for (int c = 1; c <= 15; c++) begin
      tick;
      total++; if (sigs !== 4'b0000) begin bad++; $display("FAIL simul_pre c=%0d got=%b exp=0000", c, sigs); end
    end
    tick;
    total++; if (sigs !== 4'b1010) begin bad++; $display("FAIL simul_sigs got=%b exp=1010", sigs); end
    total++; if (fvld !== 1'b1) begin bad++; $display("FAIL simul_fvld got=%b exp=1", fvld); end
    total++; if (fch !== 2'd1) begin bad++; $display("FAIL simul_fch got=%0d exp=1", fch); end
    tready = 4'b0001;
    for (int c = 0; c < 16; c++) tick;
    total++; if (sigs !== 4'b1011) begin bad++; $display("FAIL simul_late_sigs got=%b exp=1011", sigs); end
    total++; if (fch !== 2'd1) begin bad++; $display("FAIL simul_late_fch got=%0d exp=1", fch); end
  endtask

  task automatic test_enable;
    do_reset;
    tvalid = 4'b1000;
    for (int c = 0; c < 16; c++) tick;
    total++; if (sigs !== 4'b1000) begin bad++; $display("FAIL en_blk got=%b exp=1000", sigs); end
    en = 1'b0;
    tick;
    total++; if (sigs !== 4'b0000) begin bad++; $display("FAIL en_off_sigs got=%b exp=0000", sigs); end
    total++; if (any !== 1'b0) begin bad++; $display("FAIL en_off_any got=%b exp=0", any); end
    total++; if (fvld !== 1'b1) begin bad++; $display("FAIL en_off_fvld got=%b exp=1", fvld); end
    total++; if (fch !== 2'd3) begin bad++; $display("FAIL en_off_fch got=%0d exp=3", fch); end
    tick;
    en = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick;
      total++; if (sigs !== 4'b0000) begin bad++; $display("FAIL en_restart c=%0d got=%b exp=0000", c, sigs); end
    end
    tick;
    total++; if (sigs !== 4'b1000) begin bad++; $display("FAIL en_reassert got=%b exp=1000", sigs); end
  endtask

  task automatic test_reset_midrun;
    do_reset;
    tvalid = 4'b0010;
    for (int c = 0; c < 10; c++) tick;
    total++; if (smax !== 16'd9) begin bad++; $display("FAIL midrst_pre_smax got=%0d exp=9", smax); end
    reset = 1'b1;
    tick;
    total++; if (sigs !== 4'b0000) begin bad++; $display("FAIL midrst_sigs got=%b exp=0000", sigs); end
    total++; if (smax !== 16'd0) begin bad++; $display("FAIL midrst_smax got=%0d exp=0", smax); end
    total++; if (fvld !== 1'b0) begin bad++; $display("FAIL midrst_fvld got=%b exp=0", fvld); end
    reset = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      tick;
      total++; if (sigs !== 4'b0000) begin bad++; $display("FAIL midrst_cnt c=%0d got=%b exp=0000", c, sigs); end
    end
    tick;
    total++; if (sigs !== 4'b0010) begin bad++; $display("FAIL midrst_blk got=%b exp=0010", sigs); end
  endtask

  task automatic test_clear_race;
    do_reset;
    tready = 4'b0001;
    for (int c = 0; c < 20; c++) tick;
    tready = 4'b0000;
    tvalid = 4'b0100;
    for (int c = 0; c < 15; c++) tick;
    total++; if (smax !== 16'd20) begin bad++; $display("FAIL race_pre_smax got=%0d exp=20", smax); end
    total++; if (fch !== 2'd0) begin bad++; $display("FAIL race_pre_fch got=%0d exp=0", fch); end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    total++; if (fvld !== 1'b1) begin bad++; $display("FAIL race_fvld got=%b exp=1", fvld); end
    total++; if (fch !== 2'd2) begin bad++; $display("FAIL race_fch got=%0d exp=2", fch); end
    total++; if (smax !== 16'd15) begin bad++; $display("FAIL race_smax got=%0d exp=15", smax); end
    tick;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    total++; if (fvld !== 1'b0) begin bad++; $display("FAIL clr_fvld got=%b exp=0", fvld); end
    total++; if (fch !== 2'd0) begin bad++; $display("FAIL clr_fch got=%0d exp=0", fch); end
    total++; if (smax !== 16'd0) begin bad++; $display("FAIL clr_smax got=%0d exp=0", smax); end
    total++; if (sigs !== 4'b0100) begin bad++; $display("FAIL clr_sigs got=%b exp=0100", sigs); end
    tick;
    total++; if (smax !== 16'd18) begin bad++; $display("FAIL clr_smax_reload got=%0d exp=18", smax); end
    total++; if (fvld !== 1'b0) begin bad++; $display("FAIL clr_fvld_hold got=%b exp=0", fvld); end
  endtask

  task automatic test_thresh1;
    do_reset;
    t1_tready = 4'b0001;
    total++; if (d1_sigs !== 4'b0000) begin bad++; $display("FAIL t1_pre got=%b exp=0000", d1_sigs); end
    tick;
    total++; if (d1_sigs !== 4'b0001) begin bad++; $display("FAIL t1_blk got=%b exp=0001", d1_sigs); end
    total++; if (d1_any !== 1'b1) begin bad++; $display("FAIL t1_any got=%b exp=1", d1_any); end
    total++; if (d1_fvld !== 1'b1) begin bad++; $display("FAIL t1_fvld got=%b exp=1", d1_fvld); end
    total++; if (d1_fch !== 2'd0) begin bad++; $display("FAIL t1_fch got=%0d exp=0", d1_fch); end
    t1_tready = 4'b0000;
    tick;
    total++; if (d1_sigs !== 4'b0000) begin bad++; $display("FAIL t1_release got=%b exp=0000", d1_sigs); end
    t1_tready = 4'b0001;
    for (int c = 0; c < 70000; c++) tick;
    total++; if (d1_smax !== 16'hFFFF) begin bad++; $display("FAIL t1_smax got=%h exp=ffff", d1_smax); end
    total++; if (d1_sigs !== 4'b0001) begin bad++; $display("FAIL t1_long_blk got=%b exp=0001", d1_sigs); end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    total++; if (d1_smax !== 16'h0000) begin bad++; $display("FAIL t1_clr got=%h exp=0000", d1_smax); end
    tick;
    total++; if (d1_smax !== 16'hFFFF) begin bad++; $display("FAIL t1_sat got=%h exp=ffff", d1_smax); end
    t1_tready = 4'b0000;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; clear = 1'b0;
    tvalid = '0; tready = '0; t1_tvalid = '0; t1_tready = '0;
    test_reset;
    test_single_block;
    test_no_block;
    test_simultaneous;
    test_enable;
    test_reset_midrun;
    test_clear_race;
    test_thresh1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
